// File: rtl/camera_pixel_packer.sv
// Purpose : packs camera pixels into 32-bit words, stages each word and buffers it in a FWFT FIFO.
// Latency : a word is written to the FIFO one edge after its completing pixel/eof is sampled.
// Backpr. : out_valid/out_ready stream; a word arriving at a full FIFO is dropped and sets sticky overflow.
//
// Ports:
//   clk, rst_n           : clock and asynchronous active-low reset
//   in_valid/in_data     : one 10-bit pixel per strobe
//   in_eof               : end-of-frame strobe, flushes a partially filled word with last=1
//   clr_overflow         : clears the sticky overflow flag (a same-cycle drop wins)
//   out_valid/out_ready  : output handshake; out_data/out_last come from the FIFO head
//   overflow, level      : sticky drop flag and FIFO occupancy (0..FIFO_DEPTH)
//
// Build option: define PACKER_RAW10_EN for three full 10-bit lanes per word instead of
// four 8-bit lanes holding in_data[9:2].

module camera_pixel_packer #(
    parameter int FIFO_DEPTH = 16,
    parameter int FIFO_AW    = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic [9:0]         in_data,
    input  logic               in_eof,
    input  logic               clr_overflow,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_data,
    output logic               out_last,
    output logic               overflow,
    output logic [FIFO_AW:0]   level
);

`ifdef PACKER_RAW10_EN
    localparam int N      = 3;
    localparam int LANE_W = 10;
`else
    localparam int N      = 4;
    localparam int LANE_W = 8;
`endif
    localparam int               CNT_W      = 2;
    localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(N - 1);
    localparam logic [FIFO_AW:0] LEVEL_FULL = (FIFO_AW + 1)'(FIFO_DEPTH);

    // Pack state
    logic [31:0]        r_pk;
    logic [CNT_W-1:0]   r_cnt;

    // One-entry staging register {last, word}
    logic               r_stg_vld;
    logic [32:0]        r_stg_dat;

    // FIFO storage and status
    logic [32:0]        r_mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0] r_wptr;
    logic [FIFO_AW-1:0] r_rptr;
    logic [FIFO_AW:0]   r_level;
    logic               r_overflow;

    logic [LANE_W-1:0]  w_lane;
    logic [31:0]        w_pk_fill;
    logic               w_any_filled;
    logic               w_complete;
    logic               w_pop;
    logic               w_full;
    logic               w_push;
    logic               w_drop;

`ifdef PACKER_RAW10_EN
    assign w_lane = in_data;
`else
    // The two pixel LSBs are truncated away in the 8-bit lane format.
    logic w_unused_lsb;
    assign w_unused_lsb = ^in_data[1:0];
    assign w_lane       = in_data[9:2];
`endif

    // Pack register with the incoming pixel merged into lane r_cnt.
    always_comb begin
        w_pk_fill = r_pk;
        if (in_valid) begin
            for (int i = 0; i < N; i++) begin
                if (r_cnt == CNT_W'(i)) begin
                    w_pk_fill[i*LANE_W +: LANE_W] = w_lane;
                end
            end
        end
    end

    // r_pk is cleared on every completion, so r_cnt == 0 means nothing is pending
    // and a lone eof has nothing to flush.
    assign w_any_filled = in_valid || (r_cnt != '0);
    assign w_complete   = (in_valid && (r_cnt == CNT_MAX)) || (in_eof && w_any_filled);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pk      <= '0;
            r_cnt     <= '0;
            r_stg_vld <= 1'b0;
            r_stg_dat <= '0;
        end else begin
            r_stg_vld <= w_complete;
            if (w_complete) begin
                // last is set only when eof caused (or accompanied) the completion.
                r_stg_dat <= {in_eof, w_pk_fill};
                r_pk      <= '0;
                r_cnt     <= '0;
            end else if (in_valid) begin
                r_pk  <= w_pk_fill;
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign w_pop  = (r_level != '0) && out_ready;
    assign w_full = (r_level == LEVEL_FULL);
    assign w_push = r_stg_vld && (!w_full || w_pop);
    assign w_drop = r_stg_vld && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= r_stg_dat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (clr_overflow) begin
                r_overflow <= 1'b0;
            end
        end
    end

    // Head is gated by occupancy so the outputs read zero in reset and when empty.
    // The head entry only changes on a pop, which keeps it stable until accepted.
    assign out_valid = (r_level != '0);
    assign out_data  = out_valid ? r_mem[r_rptr][31:0] : 32'd0;
    assign out_last  = out_valid ? r_mem[r_rptr][32]   : 1'b0;
    assign overflow  = r_overflow;
    assign level     = r_level;

endmodule

// File: tb/tb_camera_pixel_packer.sv
module tb_camera_pixel_packer;

    localparam int DEPTH = 16;
    localparam int AW    = 4;
`ifdef PACKER_RAW10_EN
    localparam int N  = 3;
    localparam int LW = 10;
    localparam int SH = 0;
`else
    localparam int N  = 4;
    localparam int LW = 8;
    localparam int SH = 2;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic [9:0]    in_data = '0;
    logic          in_eof = 1'b0;
    logic          clr_overflow = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [31:0]   out_data;
    logic          out_last;
    logic          overflow;
    logic [AW:0]   level;

    int n_chk = 0;
    int n_err = 0;

    camera_pixel_packer #(.FIFO_DEPTH(DEPTH), .FIFO_AW(AW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_eof       (in_eof),
        .clr_overflow (clr_overflow),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_last     (out_last),
        .overflow     (overflow),
        .level        (level)
    );

    always #10 clk = ~clk;

    // Reference model: pixels of the current word, the word produced last cycle,
    // the FIFO contents as a queue, and the sticky flag.
    logic [9:0]  part[$];
    logic [32:0] mq[$];
    logic [32:0] m_stg;
    bit          m_stg_vld = 0;
    bit          m_ovf = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] pack_word();
        logic [31:0] w;
        w = 32'd0;
        for (int i = 0; i < part.size(); i++) begin
            w = w | ((32'(part[i]) >> SH) << (LW * i));
        end
        return w;
    endfunction

    task automatic model_reset();
        part.delete();
        mq.delete();
        m_stg_vld = 0;
        m_ovf = 0;
    endtask

    task automatic model_step(input bit v, input logic [9:0] d, input bit e, input bit r, input bit c);
        int  pre;
        bit  pop;
        bit  drop;
        pre  = mq.size();
        pop  = (pre != 0) && r;
        drop = 0;
        if (pop) void'(mq.pop_front());
        if (m_stg_vld) begin
            if (pre < DEPTH || pop) mq.push_back(m_stg);
            else drop = 1;
        end
        if (drop) m_ovf = 1;
        else if (c) m_ovf = 0;
        m_stg_vld = 0;
        if (v) part.push_back(d);
        if (part.size() == N || (e && part.size() > 0)) begin
            m_stg     = {e, pack_word()};
            m_stg_vld = 1;
            part.delete();
        end
    endtask

    task automatic check_outputs();
        chk("out_valid", 64'(out_valid), 64'(mq.size() != 0));
        chk("level", 64'(level), 64'(mq.size()));
        chk("overflow", 64'(overflow), 64'(m_ovf));
        if (mq.size() != 0) begin
            chk("out_data", 64'(out_data), 64'(mq[0][31:0]));
            chk("out_last", 64'(out_last), 64'(mq[0][32]));
        end
    endtask

    // One clock: drive at negedge, model the edge, check at the next negedge.
    task automatic cycle(input bit v, input logic [9:0] d, input bit e, input bit r, input bit c);
        in_valid     = v;
        in_data      = d;
        in_eof       = e;
        out_ready    = r;
        clr_overflow = c;
        @(posedge clk);
        model_step(v, d, e, r, c);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle(input int n, input bit r);
        for (int i = 0; i < n; i++) cycle(0, 10'h0, 0, r, 0);
    endtask

    task automatic do_reset();
        in_valid = 0; in_eof = 0; clr_overflow = 0;
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_level", 64'(level), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        @(negedge clk);
        do_reset();

        // Basic pack
`ifdef PACKER_RAW10_EN
        cycle(1, 10'h001, 0, 1, 0);
        cycle(1, 10'h002, 0, 1, 0);
        cycle(1, 10'h3FF, 0, 1, 0);
        chk("basic_not_yet", 64'(out_valid), 64'd0);
        idle(1, 1);
        chk("raw10_word", 64'(out_data), 64'h3FF00801);
`else
        cycle(1, 10'h004, 0, 1, 0);
        cycle(1, 10'h008, 0, 1, 0);
        cycle(1, 10'h00C, 0, 1, 0);
        cycle(1, 10'h010, 0, 1, 0);
        chk("basic_not_yet", 64'(out_valid), 64'd0);
        idle(1, 1);
        chk("basic_word", 64'(out_data), 64'h04030201);
`endif
        chk("basic_last", 64'(out_last), 64'd0);
        idle(3, 1);

        // Partial flush, then a lone eof that must produce nothing
        cycle(1, 10'h3FC, 0, 0, 0);
        cycle(1, 10'h3F8, 0, 0, 0);
        cycle(0, 10'h000, 1, 0, 0);
        idle(1, 0);
`ifndef PACKER_RAW10_EN
        chk("flush_word", 64'(out_data), 64'h0000FEFF);
`endif
        chk("flush_last", 64'(out_last), 64'd1);
        cycle(0, 10'h000, 1, 0, 0);
        idle(2, 0);
        chk("lone_eof_level", 64'(level), 64'd1);
        idle(3, 1);

        // Eof with the final pixel
        for (int i = 0; i < 8; i++) cycle(1, 10'($urandom), (i == 7), 0, 0);
        idle(2, 0);
        chk("eof8_words", 64'(level), 64'((8 + N - 1) / N));
        idle(6, 1);

        // Full and overflow
        for (int i = 0; i < 17 * N; i++) cycle(1, 10'($urandom), 0, 0, 0);
        idle(2, 0);
        chk("full_level", 64'(level), 64'(DEPTH));
        chk("full_ovf", 64'(overflow), 64'd1);
        idle(DEPTH + 4, 1);
        chk("ovf_sticky", 64'(overflow), 64'd1);
        cycle(0, 10'h0, 0, 1, 1);
        chk("ovf_cleared", 64'(overflow), 64'd0);

        // Reset mid-operation
        for (int i = 0; i < 6; i++) cycle(1, 10'($urandom), 0, 0, 0);
        do_reset();
        for (int i = 0; i < N; i++) cycle(1, 10'($urandom), 0, 1, 0);
        idle(2, 1);

        // Randomized traffic with occasional eof, stalls and clears
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 3) != 0), 10'($urandom),
                  ($urandom_range(0, 11) == 0), ($urandom_range(0, 3) < ((i / 500) % 2 ? 1 : 3)),
                  ($urandom_range(0, 40) == 0));
        end
        idle(DEPTH + 4, 1);
        chk("end_empty", 64'(level), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
